// File: rtl/instruction_decode_pkg.sv
// Shared pipeline definitions: IF/ID and ID/EX records, ALU operations,
// MIPS opcode/funct encodings and the ID/EX bubble value.
package instruction_decode_pkg;

  typedef struct packed {
    logic [31:0] pcValue;
    logic [31:0] inst;
  } pipe_IF_ID_reg_t;

  typedef enum logic [2:0] {
    ALU_NOP  = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLL  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pcValue;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm32;
    logic [4:0]  shamt;
    logic [4:0]  destReg;
    alu_op_t     aluOp;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
  } pipe_ID_EX_reg_t;

  localparam pipe_ID_EX_reg_t ID_EX_BUBBLE = '0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/instruction_decode_register_file.sv
// General-purpose register file: r0 hardwired to zero, two combinational
// read ports with write-through from the writeback port.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int REG_COUNT = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        write_enable,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data
);

  logic [31:0] regs [1:REG_COUNT-1];
  logic        wr_live;

  assign wr_live = write_enable && (write_addr != 5'd0) && !reset;

  // Storage update; r0 has no storage so it can never be written.
  always_ff @(posedge clock or posedge reset) begin
    for (int i = 1; i < REG_COUNT; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (wr_live && (write_addr == 5'(i))) begin
        regs[i] <= write_data;
      end
    end
  end

  // Read port rs, bypassing a same-cycle writeback.
  always_comb begin
    rs_data = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (rs_addr == 5'(i)) rs_data = regs[i];
    end
    if (wr_live && (write_addr == rs_addr)) rs_data = write_data;
  end

  // Read port rt, bypassing a same-cycle writeback.
  always_comb begin
    rt_data = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (rt_addr == 5'(i)) rt_data = regs[i];
    end
    if (wr_live && (write_addr == rt_addr)) rt_data = write_data;
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: field decode, hazard detection, branch/jump resolution with
// MEM-stage operand forwarding, and the ID/EX pipeline register.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int LINK_REG  = 31,
  parameter int REG_COUNT = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  pipe_IF_ID_reg_t pipelineFetchRes,
  input  logic            wbWriteEnable,
  input  logic [4:0]      wbWriteAddr,
  input  logic [31:0]     wbWriteData,
  input  logic [4:0]      exDestReg,
  input  logic            exRegWrite,
  input  logic            exIsLoad,
  input  logic [4:0]      memDestReg,
  input  logic            memRegWrite,
  input  logic            memIsLoad,
  input  logic [31:0]     memForwardData,
  output logic            stallFromDecode,
  output logic            jumpEnable,
  output logic [31:0]     jumpValue,
  output pipe_ID_EX_reg_t pipelineDecodeRes
);

  logic [31:0] pc, inst, pc_plus4, sext;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic [31:0] rs_data, rt_data, br_rs, br_rt;
  logic        wr, valid, uses_rs, uses_rt, is_beq, is_bne, is_jr, is_j;
  logic        ex_hit_rs, ex_hit_rt, mem_ld_rs, mem_ld_rt, mem_fw_rs, mem_fw_rt;
  logic        load_use, branch_haz, hazard, taken;
  pipe_ID_EX_reg_t dec;

  assign pc       = pipelineFetchRes.pcValue;
  assign inst     = pipelineFetchRes.inst;
  assign opcode   = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign funct    = inst[5:0];
  assign pc_plus4 = pc + 32'd4;
  assign sext     = {{16{inst[15]}}, inst[15:0]};

  register_file #(.REG_COUNT(REG_COUNT)) u_register_file (
    .clock        (clock),
    .reset        (reset),
    .rs_addr      (rs),
    .rt_addr      (rt),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .write_enable (wbWriteEnable),
    .write_addr   (wbWriteAddr),
    .write_data   (wbWriteData)
  );

  // Decode the fetched word into an ID/EX record plus source-usage flags.
  always_comb begin
    dec         = ID_EX_BUBBLE;
    dec.pcValue = pc;
    dec.rsData  = rs_data;
    dec.rtData  = rt_data;
    dst     = '0;
    wr      = 1'b0;
    valid   = 1'b1;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jr   = 1'b0;
    is_j    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dst = rd; wr = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
        case (funct)
          FN_ADDU: dec.aluOp = ALU_ADD;
          FN_SUBU: dec.aluOp = ALU_SUB;
          FN_AND:  dec.aluOp = ALU_AND;
          FN_OR:   dec.aluOp = ALU_OR;
          FN_SLT:  dec.aluOp = ALU_SLT;
          FN_SLL: begin
            dec.aluOp = ALU_SLL; dec.shamt = inst[10:6]; uses_rs = 1'b0;
          end
          FN_JR: begin
            is_jr = 1'b1; dst = '0; wr = 1'b0; uses_rt = 1'b0;
          end
          default: valid = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        dec.aluOp = ALU_ADD; dec.imm32 = sext; dst = rt; wr = 1'b1; uses_rs = 1'b1;
      end
      OP_ORI: begin
        dec.aluOp = ALU_OR; dec.imm32 = {16'd0, inst[15:0]}; dst = rt; wr = 1'b1;
        uses_rs = 1'b1;
      end
      OP_LUI: begin
        dec.aluOp = ALU_PASS; dec.imm32 = {inst[15:0], 16'd0}; dst = rt; wr = 1'b1;
      end
      OP_LW: begin
        dec.aluOp = ALU_ADD; dec.imm32 = sext; dst = rt; wr = 1'b1; uses_rs = 1'b1;
        dec.memRead = 1'b1; dec.memToReg = 1'b1;
      end
      OP_SW: begin
        dec.aluOp = ALU_ADD; dec.imm32 = sext; uses_rs = 1'b1; uses_rt = 1'b1;
        dec.memWrite = 1'b1;
      end
      OP_BEQ: begin
        dec.imm32 = sext; is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BNE: begin
        dec.imm32 = sext; is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin
        is_j = 1'b1; dec.aluOp = ALU_PASS; dec.imm32 = pc + 32'd8;
        dst = 5'(LINK_REG); wr = 1'b1;
      end
      default: valid = 1'b0;
    endcase
    dec.destReg  = dst;
    dec.regWrite = wr && (dst != 5'd0);
    if (!valid) begin
      dec     = ID_EX_BUBBLE;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
    end
  end

  assign ex_hit_rs = exRegWrite && (exDestReg != 5'd0) && (exDestReg == rs);
  assign ex_hit_rt = exRegWrite && (exDestReg != 5'd0) && (exDestReg == rt);
  assign mem_ld_rs = memRegWrite && memIsLoad && (memDestReg != 5'd0) && (memDestReg == rs);
  assign mem_ld_rt = memRegWrite && memIsLoad && (memDestReg != 5'd0) && (memDestReg == rt);
  assign mem_fw_rs = memRegWrite && !memIsLoad && (memDestReg != 5'd0) && (memDestReg == rs);
  assign mem_fw_rt = memRegWrite && !memIsLoad && (memDestReg != 5'd0) && (memDestReg == rt);

  assign load_use   = exIsLoad && ((uses_rs && ex_hit_rs) || (uses_rt && ex_hit_rt));
  assign branch_haz = ((is_beq || is_bne) && (ex_hit_rs || ex_hit_rt || mem_ld_rs || mem_ld_rt))
                    || (is_jr && (ex_hit_rs || mem_ld_rs));
  assign hazard     = load_use || branch_haz;

  assign br_rs = mem_fw_rs ? memForwardData : rs_data;
  assign br_rt = mem_fw_rt ? memForwardData : rt_data;
  assign taken = (is_beq && (br_rs == br_rt)) || (is_bne && (br_rs != br_rt)) || is_j || is_jr;

  assign stallFromDecode = !reset && hazard;
  assign jumpEnable      = !reset && taken && !hazard;

  // Redirect target selection for jump-register, absolute jumps and branches.
  always_comb begin
    if (is_jr)     jumpValue = br_rs;
    else if (is_j) jumpValue = {pc_plus4[31:28], inst[25:0], 2'b00};
    else           jumpValue = pc_plus4 + {sext[29:0], 2'b00};
  end

  // ID/EX register: a bubble is inserted on reset or whenever decode stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       pipelineDecodeRes <= ID_EX_BUBBLE;
    else if (hazard) pipelineDecodeRes <= ID_EX_BUBBLE;
    else             pipelineDecodeRes <= dec;
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed testbench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;
  import instruction_decode_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  pipe_IF_ID_reg_t pipelineFetchRes;
  logic            wbWriteEnable;
  logic [4:0]      wbWriteAddr;
  logic [31:0]     wbWriteData;
  logic [4:0]      exDestReg;
  logic            exRegWrite;
  logic            exIsLoad;
  logic [4:0]      memDestReg;
  logic            memRegWrite;
  logic            memIsLoad;
  logic [31:0]     memForwardData;
  logic            stallFromDecode;
  logic            jumpEnable;
  logic [31:0]     jumpValue;
  pipe_ID_EX_reg_t pipelineDecodeRes;

  int checks = 0;
  int errors = 0;

  localparam pipe_ID_EX_reg_t BUB = '0;

  instruction_decode dut (
    .clock             (clock),
    .reset             (reset),
    .pipelineFetchRes  (pipelineFetchRes),
    .wbWriteEnable     (wbWriteEnable),
    .wbWriteAddr       (wbWriteAddr),
    .wbWriteData       (wbWriteData),
    .exDestReg         (exDestReg),
    .exRegWrite        (exRegWrite),
    .exIsLoad          (exIsLoad),
    .memDestReg        (memDestReg),
    .memRegWrite       (memRegWrite),
    .memIsLoad         (memIsLoad),
    .memForwardData    (memForwardData),
    .stallFromDecode   (stallFromDecode),
    .jumpEnable        (jumpEnable),
    .jumpValue         (jumpValue),
    .pipelineDecodeRes (pipelineDecodeRes)
  );

  always #5 clock = ~clock;

  function automatic pipe_ID_EX_reg_t mk(input logic [31:0] pc, rsd, rtd, imm,
                                         input logic [4:0] sh, dst, input alu_op_t op,
                                         input logic rw, mr, mw, m2r);
    pipe_ID_EX_reg_t r;
    r.pcValue = pc;  r.rsData = rsd; r.rtData = rtd; r.imm32 = imm;
    r.shamt = sh;    r.destReg = dst; r.aluOp = op;   r.regWrite = rw;
    r.memRead = mr;  r.memWrite = mw; r.memToReg = m2r;
    return r;
  endfunction

  task automatic chk_rec(input string tag, input pipe_ID_EX_reg_t got, input pipe_ID_EX_reg_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wbWriteEnable = 1'b0; wbWriteAddr = '0; wbWriteData = '0;
    exDestReg = '0; exRegWrite = 1'b0; exIsLoad = 1'b0;
    memDestReg = '0; memRegWrite = 1'b0; memIsLoad = 1'b0; memForwardData = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] i);
    pipelineFetchRes.pcValue = pc;
    pipelineFetchRes.inst    = i;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wbWriteEnable = 1'b1; wbWriteAddr = a; wbWriteData = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    // JR r1 with EX writing r1 would stall, but reset masks everything
    fetch(32'h0, 32'h0020_0008);
    exDestReg = 5'd1; exRegWrite = 1'b1;
    #2;
    chk_rec("reset_rec", pipelineDecodeRes, BUB);
    chk_bit("reset_stall", stallFromDecode, 1'b0);
    chk_bit("reset_jump", jumpEnable, 1'b0);
    step();
    chk_rec("reset_rec_edge", pipelineDecodeRes, BUB);
    reset = 1'b0;
    idle();

    // preload r1=7, r2=7 with NOPs in decode
    fetch(32'h0, 32'h0);
    wb(5'd1, 32'd7);
    step();
    wb(5'd2, 32'd7);
    step();
    idle();

    // ADDU r9,r8,r8 with same-cycle WB of r8
    fetch(32'h10, 32'h0108_4821);
    wb(5'd8, 32'd5);
    step();
    idle();
    chk_rec("addu_bypass", pipelineDecodeRes, mk(32'h10, 32'd5, 32'd5, 0, 0, 5'd9, ALU_ADD, 1, 0, 0, 0));

    // load-use: EX holds LW r4, decode ADDU r5,r4,r0
    fetch(32'h20, 32'h0080_2821);
    exDestReg = 5'd4; exRegWrite = 1'b1; exIsLoad = 1'b1;
    #1;
    chk_bit("lu_stall", stallFromDecode, 1'b1);
    step();
    chk_rec("lu_bubble", pipelineDecodeRes, BUB);
    idle();
    wb(5'd4, 32'h0000_1234);
    #1;
    chk_bit("lu_retry_nostall", stallFromDecode, 1'b0);
    step();
    idle();
    chk_rec("lu_retry", pipelineDecodeRes, mk(32'h20, 32'h1234, 0, 0, 0, 5'd5, ALU_ADD, 1, 0, 0, 0));

    // BEQ r1,r2,+3 at 0x100, taken
    fetch(32'h100, 32'h1022_0003);
    #1;
    chk_bit("beq_jump", jumpEnable, 1'b1);
    chk_word("beq_target", jumpValue, 32'h110);
    chk_bit("beq_nostall", stallFromDecode, 1'b0);
    step();
    chk_rec("beq_rec", pipelineDecodeRes, mk(32'h100, 7, 7, 3, 0, 0, ALU_NOP, 0, 0, 0, 0));
    // delay slot ORI r10,r1,0xF0 still issues
    fetch(32'h104, 32'h342A_00F0);
    #1;
    chk_bit("slot_nojump", jumpEnable, 1'b0);
    step();
    chk_rec("slot_ori", pipelineDecodeRes, mk(32'h104, 7, 0, 32'hF0, 0, 5'd10, ALU_OR, 1, 0, 0, 0));

    // BEQ r1,r3 not taken (r3=0)
    fetch(32'h108, 32'h1023_0003);
    #1;
    chk_bit("beq_not_taken", jumpEnable, 1'b0);

    // BNE r3,r0 using MEM-forwarded r3=1
    fetch(32'h300, 32'h1460_0010);
    memDestReg = 5'd3; memRegWrite = 1'b1; memIsLoad = 1'b0; memForwardData = 32'h1;
    #1;
    chk_bit("bne_fwd_jump", jumpEnable, 1'b1);
    chk_word("bne_fwd_target", jumpValue, 32'h344);
    chk_bit("bne_fwd_nostall", stallFromDecode, 1'b0);
    idle();

    // branch hazard from EX (non-load) writing r1
    fetch(32'h100, 32'h1022_0003);
    exDestReg = 5'd1; exRegWrite = 1'b1;
    #1;
    chk_bit("br_ex_stall", stallFromDecode, 1'b1);
    chk_bit("br_ex_nojump", jumpEnable, 1'b0);
    step();
    chk_rec("br_ex_bubble", pipelineDecodeRes, BUB);
    idle();
    // branch hazard from a load in MEM writing r2
    memDestReg = 5'd2; memRegWrite = 1'b1; memIsLoad = 1'b1;
    #1;
    chk_bit("br_memld_stall", stallFromDecode, 1'b1);
    idle();

    // JAL 0x40 at 0x200
    fetch(32'h200, 32'h0C00_0040);
    #1;
    chk_bit("jal_jump", jumpEnable, 1'b1);
    chk_word("jal_target", jumpValue, 32'h100);
    step();
    chk_rec("jal_rec", pipelineDecodeRes, mk(32'h200, 0, 0, 32'h208, 0, 5'd31, ALU_PASS, 1, 0, 0, 0));

    // JR r1
    fetch(32'h204, 32'h0020_0008);
    #1;
    chk_bit("jr_jump", jumpEnable, 1'b1);
    chk_word("jr_target", jumpValue, 32'h7);

    // immediates and memory ops
    fetch(32'h210, 32'h240B_FFFF);
    step();
    chk_rec("addiu_sext", pipelineDecodeRes, mk(32'h210, 0, 0, 32'hFFFF_FFFF, 0, 5'd11, ALU_ADD, 1, 0, 0, 0));
    fetch(32'h214, 32'h3C0C_8001);
    step();
    chk_rec("lui", pipelineDecodeRes, mk(32'h214, 0, 0, 32'h8001_0000, 0, 5'd12, ALU_PASS, 1, 0, 0, 0));
    fetch(32'h218, 32'hAC22_0008);
    step();
    chk_rec("sw", pipelineDecodeRes, mk(32'h218, 7, 7, 8, 0, 0, ALU_ADD, 0, 0, 1, 0));
    fetch(32'h21C, 32'h8C2D_0004);
    step();
    chk_rec("lw", pipelineDecodeRes, mk(32'h21C, 7, 0, 4, 0, 5'd13, ALU_ADD, 1, 1, 0, 1));
    fetch(32'h220, 32'h0002_70C0);
    step();
    chk_rec("sll", pipelineDecodeRes, mk(32'h220, 0, 7, 0, 5'd3, 5'd14, ALU_SLL, 1, 0, 0, 0));
    fetch(32'h224, 32'hFC00_0000);
    step();
    chk_rec("illegal_bubble", pipelineDecodeRes, BUB);
    fetch(32'h228, 32'h0021_0021);
    step();
    chk_rec("dest_r0_nowrite", pipelineDecodeRes, mk(32'h228, 7, 7, 0, 0, 0, ALU_ADD, 0, 0, 0, 0));

    // reset pulse mid-stall
    fetch(32'h22C, 32'h0080_2821);
    exDestReg = 5'd4; exRegWrite = 1'b1; exIsLoad = 1'b1;
    #1;
    chk_bit("pre_reset_stall", stallFromDecode, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk_rec("midreset_bubble", pipelineDecodeRes, BUB);
    chk_bit("midreset_stall", stallFromDecode, 1'b0);
    #1;
    reset = 1'b0;
    idle();
    fetch(32'h230, 32'h0020_2821);
    step();
    chk_rec("post_reset_r1", pipelineDecodeRes, mk(32'h230, 0, 0, 0, 0, 5'd5, ALU_ADD, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameter LINK_REG, default 31: register written by JAL with the return address.
REQ-002 Parameter REG_COUNT, default 32: number of general-purpose registers.
REQ-003 clock  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pipelineFetchRes  input  pipe_IF_ID_reg_t (64)  pcValue and inst from the fetch stage.
REQ-006 wbWriteEnable / wbWriteAddr / wbWriteData  input  1/5/32  register-file write port from writeback.
REQ-007 exDestReg / exRegWrite / exIsLoad  input  5/1/1  destination info of the instruction now in EX.
REQ-008 memDestReg / memRegWrite / memIsLoad / memForwardData  input  5/1/1/32  destination info and ALU result of the instruction now in MEM.
REQ-009 stallFromDecode  output  1  combinational; holds PC and IF/ID register.
REQ-010 jumpEnable / jumpValue  output  1/32  combinational redirect to the PC.
REQ-011 pipelineDecodeRes  output  pipe_ID_EX_reg_t  registered ID/EX record.

Function
REQ-012 Supported instructions: ADDU, SUBU, AND, OR, SLT, SLL, JR, ADDIU, ORI, LUI, LW, SW, BEQ, BNE, J, JAL; any other encoding decodes as a bubble (all control zero).
REQ-013 ID/EX record fields: pcValue, rsData, rtData, imm32, shamt, destReg, aluOp, regWrite, memRead, memWrite, memToReg.
REQ-014 Immediate extension: ORI zero-extends; LUI produces imm<<16; all other I-type instructions sign-extend.
REQ-015 destReg is rd for R-type, rt for I-type loads/ALU ops, LINK_REG for JAL; regWrite is forced 0 when destReg is 0.
REQ-016 JAL writes pcValue+8 through the ALU path (aluOp = pass, imm32 = pcValue+8).
REQ-017 Latency: an instruction present in pipelineFetchRes at edge N appears in pipelineDecodeRes at edge N+1.
REQ-018 Load-use hazard: asserted when exIsLoad and exRegWrite and exDestReg!=0 and exDestReg equals a used rs or rt.
REQ-019 Branch/JR hazard: asserted when a BEQ/BNE/JR source equals exDestReg with exRegWrite, or equals memDestReg with memRegWrite and memIsLoad.
REQ-020 On any hazard: stallFromDecode=1, a bubble is written into ID/EX, jumpEnable=0, and the decode is retried next cycle.
REQ-021 Branch/JR operands take memForwardData when memRegWrite, !memIsLoad and memDestReg matches (nonzero); otherwise they use register-file data.
REQ-022 Redirect targets:
- BEQ/BNE taken: jumpValue = pcValue+4+(signext(imm)<<2).
- J/JAL: {pcValue+4[31:28], target, 2'b00}.
- JR: rs value.
- jumpEnable=1 only when the redirect is taken and there is no stall.
REQ-023 One delay slot is architectural: the instruction already fetched after a branch or jump is executed and never flushed.
REQ-024 Register file:
- register 0 always reads 0;
- a write occurs on the rising edge when wbWriteEnable and wbWriteAddr!=0;
- reads are combinational with write-through (same-cycle WB write to a read address returns wbWriteData).
REQ-025 Simultaneous load-use and branch hazards produce a single stall cycle per cycle evaluated; no other priority is needed.

Reset
REQ-026 While reset is high: pipelineDecodeRes holds a bubble (all fields zero), every register reads 0, and stallFromDecode and jumpEnable are 0 regardless of other inputs.
REQ-027 Reset asserted mid-operation takes effect immediately (asynchronous); the first decode occurs on the first rising edge after deassertion.

Structure
REQ-028 pipe_ID_EX_reg_t, the aluOp enum, opcode/funct constants and the ID/EX bubble value belong in the shared definitions package next to pipe_IF_ID_reg_t.
REQ-029 The register file is a separate sub-module named register_file; hazard, decode and branch logic stay in instruction_decode.

Verification
REQ-030 Scenario: WB writes r8=0x00000005 in the same cycle ADDU r9,r8,r8 is decoded -> rsData=rtData=5 (bypass), destReg=9, regWrite=1.
REQ-031 Scenario: EX holds LW r4 and ID holds ADDU r5,r4,r0 -> one cycle with stallFromDecode=1 and a bubble in ID/EX, then the ADDU is issued with rsData = the WB-written value.
REQ-032 Scenario: BEQ r1,r2,+3 at pc 0x100 with r1=r2=7 -> jumpEnable=1, jumpValue=0x110, and the delay-slot instruction still reaches ID/EX.
REQ-033 Scenario: BNE r3,r0 with MEM holding a non-load ALU result to r3 of 0x1 -> forwarded operand used, jumpEnable=1, no stall.
REQ-034 Scenario: JAL 0x0040 at pc 0x200 -> jumpValue=0x100, destReg=31, imm32=0x208.
REQ-035 Scenario: reset pulse asserted between clock edges mid-stall -> pipelineDecodeRes immediately becomes a bubble, stallFromDecode=0, and r1 reads 0 afterwards.
